// File: rtl/video_delay_if.sv
// Sample bus for video_delay: requested tap, flush, sample in, and delayed
// sample / valid / fill status back out.
interface video_delay_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_DELAY = 8
);
  localparam int TW = $clog2(MAX_DELAY + 1);

  logic [TW-1:0]    tap;
  logic             flush;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [TW-1:0]    fill;

  modport master (output tap, flush, in, input out, valid, fill);
  modport slave  (input tap, flush, in, output out, valid, fill);
endinterface

// File: rtl/video_delay.sv
// Runtime-tapped multi-bit delay line with fill tracking and synchronous flush.
// Optional build macro VIDEO_DELAY_FILL_EN: drive FILL_VALUE on out while not valid.
module video_delay #(
  parameter int               WIDTH      = 4,
  parameter int               MAX_DELAY  = 8,
  parameter logic [WIDTH-1:0] FILL_VALUE = {WIDTH{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  video_delay_if.slave bus
);
  localparam int TW = $clog2(MAX_DELAY + 1);

`ifdef VIDEO_DELAY_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic [WIDTH-1:0] s [1:MAX_DELAY];
  logic [TW-1:0]    fill_q;
  logic [TW-1:0]    tap_eff;
  logic [WIDTH-1:0] raw;
  logic             valid_c;

  // Out-of-range taps clamp to the deepest stage rather than wrapping.
  assign tap_eff = (bus.tap > TW'(MAX_DELAY)) ? TW'(MAX_DELAY) : bus.tap;

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      for (int k = 1; k <= MAX_DELAY; k++) s[k] <= '0;
      fill_q <= '0;
    end else begin
      s[1] <= bus.in;
      for (int k = 2; k <= MAX_DELAY; k++) s[k] <= s[k-1];
      if (fill_q != TW'(MAX_DELAY)) fill_q <= fill_q + 1'b1;
    end
  end

  always_comb begin
    raw = bus.in;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (tap_eff == TW'(k)) raw = s[k];
    end
  end

  assign valid_c   = (tap_eff == '0) || (fill_q >= tap_eff);
  assign bus.valid = valid_c;
  assign bus.fill  = fill_q;
  assign bus.out   = (FILL_EN && !valid_c) ? FILL_VALUE : raw;
endmodule

// File: tb/tb_video_delay.sv
// Directed bench for video_delay: vector table plus model-checked sequences
// for latency sweep, clamping, flush and retap.
module tb_video_delay;
  localparam int W  = 4;
  localparam int MD = 8;
`ifdef VIDEO_DELAY_FILL_EN
  localparam logic [3:0] FILLV = 4'hC;
`else
  localparam logic [3:0] FILLV = 4'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_delay_if #(.WIDTH(W), .MAX_DELAY(MD)) bus ();

  video_delay #(.WIDTH(W), .MAX_DELAY(MD), .FILL_VALUE(4'hC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] tap;
    logic [3:0] din;
    logic [3:0] out;   // raw tapped stage; replaced by FILLV when invalid
    logic       valid;
    logic [3:0] fill;
  } vec_t;

  vec_t tbl [16];
  int checks = 0;
  int failures = 0;

  // reference model state: samples since last reset/flush, newest first
  logic [3:0] hist [$];
  int n = 0;
  logic last_valid;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int t, input bit fl, input logic [3:0] d);
    int te, ef;
    bit ev;
    logic [3:0] rawv, eo;
    @(negedge clk);
    rst = 1'b1;
    bus.tap = 4'(t);
    bus.flush = fl;
    bus.in = d;
    #1;
    te = (t > MD) ? MD : t;
    ef = (n > MD) ? MD : n;
    ev = (te == 0) || (ef >= te);
    if (te == 0) rawv = d;
    else if (n >= te) rawv = hist[te-1];
    else rawv = 4'h0;
    eo = ev ? rawv : FILLV;
    chk("seq_out", int'(bus.out), int'(eo));
    chk("seq_valid", int'(bus.valid), int'(ev));
    chk("seq_fill", int'(bus.fill), ef);
    last_valid = bus.valid;
    @(posedge clk);
    if (fl) begin
      hist.delete();
      n = 0;
    end else begin
      hist.push_front(d);
      if (hist.size() > MD) void'(hist.pop_back());
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in = 4'h0;
    @(posedge clk);
    hist.delete();
    n = 0;
  endtask

  initial begin
    int cnt, lowcnt;
    logic [3:0] eo;
    //          rst  fl   tap    din    out    v     fill
    tbl[0]  = '{1'b0, 1'b0, 4'd3,  4'h5, 4'h0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd3,  4'h1, 4'h0, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd3,  4'h2, 4'h0, 1'b0, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 4'd3,  4'h3, 4'h0, 1'b0, 4'd2};
    tbl[4]  = '{1'b1, 1'b0, 4'd3,  4'h4, 4'h1, 1'b1, 4'd3};
    tbl[5]  = '{1'b1, 1'b0, 4'd0,  4'h9, 4'h9, 1'b1, 4'd4};
    tbl[6]  = '{1'b1, 1'b0, 4'd12, 4'h6, 4'h0, 1'b0, 4'd5};
    tbl[7]  = '{1'b1, 1'b0, 4'd2,  4'h7, 4'h9, 1'b1, 4'd6};
    tbl[8]  = '{1'b1, 1'b0, 4'd7,  4'h8, 4'h1, 1'b1, 4'd7};
    tbl[9]  = '{1'b1, 1'b1, 4'd8,  4'hA, 4'h1, 1'b1, 4'd8};
    tbl[10] = '{1'b1, 1'b0, 4'd8,  4'hB, 4'h0, 1'b0, 4'd0};
    tbl[11] = '{1'b1, 1'b1, 4'd1,  4'hD, 4'hB, 1'b1, 4'd1};
    tbl[12] = '{1'b1, 1'b1, 4'd1,  4'hE, 4'h0, 1'b0, 4'd0};
    tbl[13] = '{1'b1, 1'b0, 4'd0,  4'h3, 4'h3, 1'b1, 4'd0};
    tbl[14] = '{1'b0, 1'b1, 4'd1,  4'h5, 4'h3, 1'b1, 4'd1};
    tbl[15] = '{1'b1, 1'b0, 4'd1,  4'h2, 4'h0, 1'b0, 4'd0};

    rst = 1'b0;
    bus.tap = 4'd3;
    bus.flush = 1'b0;
    bus.in = 4'h0;
    @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      bus.flush = tbl[i].flush;
      bus.tap = tbl[i].tap;
      bus.in = tbl[i].din;
      #1;
      eo = tbl[i].valid ? tbl[i].out : FILLV;
      chk($sformatf("vec%0d_out", i), int'(bus.out), int'(eo));
      chk($sformatf("vec%0d_valid", i), int'(bus.valid), int'(tbl[i].valid));
      chk($sformatf("vec%0d_fill", i), int'(bus.fill), int'(tbl[i].fill));
      @(posedge clk);
    end

    // latency sweep, tap held 20 cycles at each value
    do_reset();
    cnt = 0;
    for (int t = 0; t <= MD; t++) begin
      for (int c = 0; c < 20; c++) begin
        cyc(t, 1'b0, 4'(cnt % 16));
        cnt++;
      end
    end

    // clamp: tap=12 must behave as tap=8
    do_reset();
    lowcnt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(12, 1'b0, 4'(c + 1));
      if (!last_valid) lowcnt++;
    end
    chk("clamp_low_cycles", lowcnt, 8);

    // flush mid-stream at tap=5; the flushed 0xA must never emerge
    do_reset();
    for (int c = 0; c < 10; c++) cyc(5, 1'b0, 4'(c + 1));
    cyc(5, 1'b1, 4'hA);
    lowcnt = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(5, 1'b0, 4'(c + 3));
      if (!last_valid) lowcnt++;
    end
    chk("flush_low_cycles", lowcnt, 5);

    // held flush keeps everything cleared
    for (int c = 0; c < 3; c++) cyc(2, 1'b1, 4'hF);
    chk("flush_hold_fill", int'(bus.fill), 0);

    // retap 2 -> 7 with fill=4, then back to 2
    do_reset();
    for (int c = 0; c < 4; c++) cyc(2, 1'b0, 4'(c + 5));
    cyc(7, 1'b0, 4'h1);
    chk("retap_drop", int'(last_valid), 0);
    cnt = 0;
    while (!last_valid && cnt < 12) begin
      cyc(7, 1'b0, 4'(cnt + 2));
      cnt++;
    end
    chk("retap_rise_cycles", cnt, 3);
    cyc(2, 1'b0, 4'h4);
    chk("retap_back_valid", int'(last_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_delay.md
# video_delay

Parametrised multi-bit delay line with a runtime-selectable delay, a fill tracker and a synchronous flush. It aligns pixel-clock-domain video control signals (hsync, vsync, enable, attribute bits) with the character ROM/RAM fetch latency in the MDA pipeline. It replaces the fixed single-bit shift delay: any bit width, any depth up to a compile-time maximum, and the delay can change at run time without re-synthesis.

## Interface
Parameters:
- WIDTH, 4: bits per sample.
- MAX_DELAY, 8: deepest supported delay in clock cycles; must be ≥1.
- FILL_VALUE, {WIDTH{1'b0}}: value driven on out while not valid (only with VIDEO_DELAY_FILL_EN).

Ports:
- clk  in  1  pixel clock. One clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low. rst==0 at a rising clk edge resets the block.
- tap  in  $clog2(MAX_DELAY+1)  requested delay in cycles, 0..MAX_DELAY; may change any cycle.
- flush  in  1  synchronous clear of the pipeline contents and fill count.
- in  in  WIDTH  sample entering the line.
- out  out  WIDTH  sample delayed by the effective tap.
- valid  out  1  high when out carries a sample captured after the last reset/flush.
- fill  out  $clog2(MAX_DELAY+1)  cycles since last reset/flush, saturating at MAX_DELAY.

## Operation
- Storage: stages s[1..MAX_DELAY], each WIDTH bits; s[k] holds in from k edges earlier.
- tap_eff = min(tap, MAX_DELAY); out-of-range values are clamped, never wrapped.
- Normal edge (rst==1, flush==0): s[1]<=in, s[k]<=s[k-1] for k=2..MAX_DELAY; fill<=min(fill+1, MAX_DELAY).
- Flush edge (rst==1, flush==1): all s[k]<=0, fill<=0; the in sample of that cycle is discarded.
- Reset edge (rst==0): all s[k]<=0, fill<=0; overrides flush.
- out = in when tap_eff==0, else s[tap_eff]; combinational mux from registers (tap=0 is a pass-through).
- valid = (tap_eff==0) || (fill ≥ tap_eff); combinational from fill and tap.
- Tap change: no pipeline disturbance; out switches to the new stage in the same cycle. Raising tap above fill drops valid until fill catches up; lowering it never drops valid.
- fill saturates; it never wraps.

## Timing
- Latency in→out: exactly tap_eff rising edges; 0 edges for tap_eff==0.
- After reset/flush with constant tap=N≥1: valid low for N cycles, first high in the cycle following the N-th normal edge; out in that cycle equals in from the first post-flush cycle.
- Reset values: s[*]=0, fill=0, so out=0 (or FILL_VALUE, see Configuration) and valid=(tap_eff==0).
- flush held high for several cycles: pipeline stays cleared and fill stays 0 throughout.
- tap and flush in the same cycle: flush applies at the edge; valid is evaluated against the new tap.

## Configuration
- VIDEO_DELAY_FILL_EN defined: out = FILL_VALUE whenever valid==0, else the tapped sample. Lets blanking-level defaults (e.g. hsync inactive) appear during pipeline refill.
- Not defined: out is always the raw tapped stage (zeros after reset/flush); FILL_VALUE unused.
- valid, fill and stage behaviour are identical in both builds.

## Test plan
- Reset: WIDTH=4, MAX_DELAY=8, tap=3, rst=0 for 2 edges -> out=0, valid=0, fill=0; after release, valid rises after 3rd edge, fill saturates at 8 after 8 edges.
- Latency sweep: in = cycle counter mod 16, tap stepped 0..8 (held 20 cycles each) -> out == in delayed by exactly tap cycles once valid; tap=0 gives out==in same cycle.
- Clamp: tap=12 with MAX_DELAY=8 (tap width 4) -> behaves as tap=8, valid after 8 edges.
- Flush mid-stream: tap=5, steady stream, flush for 1 cycle with in=0xA -> 0xA never appears on out, valid low 5 cycles, fill restarts at 0.
- Retap: filled pipeline at tap=2, switch to tap=7 with fill=4 -> valid drops same cycle, rises when fill reaches 7; switch back to tap=2 -> valid high immediately.
- Fill value: build with VIDEO_DELAY_FILL_EN and FILL_VALUE=4'hC, tap=4 after reset -> out=4'hC for 4 cycles, then the delayed stream; without the macro -> out=0 for those cycles.
